// File: rtl/gmii_mii_sdr_adapter.sv
// GMII/MII mode adapter between the MAC byte interface and SDR PHY I/O registers.
// GMII passes bytes through; MII splits/reassembles nibbles, low nibble first.
module gmii_mii_sdr_adapter #(
  parameter int ENABLE_MII     = 1,
  parameter int RX_DRIBBLE_ERR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_enable,
  input  logic       mii_select,
  output logic       mode_mii,
  input  logic [7:0] mac_txd,
  input  logic       mac_tx_en,
  input  logic       mac_tx_er,
  output logic       mac_tx_ready,
  output logic [7:0] phy_txd,
  output logic       phy_tx_en,
  output logic       phy_tx_er,
  input  logic [7:0] phy_rxd,
  input  logic       phy_rx_dv,
  input  logic       phy_rx_er,
  output logic [7:0] mac_rxd,
  output logic       mac_rx_dv,
  output logic       mac_rx_er,
  output logic       mac_rx_valid
);

  logic       tx_phase;
  logic [3:0] tx_hi;
  logic       tx_en_q;
  logic       tx_er_q;
  logic       rx_phase;
  logic [3:0] rx_lo;
  logic       rx_err;
  logic       idle;

  // Mode may only change when neither direction is mid-frame or mid-byte.
  assign idle = !tx_phase && !phy_tx_en && !mac_tx_en && !rx_phase && !phy_rx_dv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mode_mii <= 1'b0;
    else if (clk_enable && idle)
      mode_mii <= (ENABLE_MII != 0) && mii_select;
  end

  assign mac_tx_ready = clk_enable && !(mode_mii && tx_phase);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_phase  <= 1'b0;
      tx_hi     <= 4'h0;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      phy_txd   <= 8'h00;
      phy_tx_en <= 1'b0;
      phy_tx_er <= 1'b0;
    end else if (clk_enable) begin
      if (!mode_mii) begin
        phy_txd   <= mac_txd;
        phy_tx_en <= mac_tx_en;
        phy_tx_er <= mac_tx_er;
        tx_phase  <= 1'b0;
      end else if (!tx_phase) begin
        tx_hi     <= mac_txd[7:4];
        tx_en_q   <= mac_tx_en;
        tx_er_q   <= mac_tx_er;
        phy_txd   <= {4'h0, mac_txd[3:0]};
        phy_tx_en <= mac_tx_en;
        phy_tx_er <= mac_tx_er;
        tx_phase  <= mac_tx_en;
      end else begin
        // Second half of the byte repeats the enable/error captured with it.
        phy_txd   <= {4'h0, tx_hi};
        phy_tx_en <= tx_en_q;
        phy_tx_er <= tx_er_q;
        tx_phase  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_phase     <= 1'b0;
      rx_lo        <= 4'h0;
      rx_err       <= 1'b0;
      mac_rxd      <= 8'h00;
      mac_rx_dv    <= 1'b0;
      mac_rx_er    <= 1'b0;
      mac_rx_valid <= 1'b0;
    end else begin
      mac_rx_valid <= 1'b0;
      if (clk_enable) begin
        if (!mode_mii) begin
          mac_rxd      <= phy_rxd;
          mac_rx_dv    <= phy_rx_dv;
          mac_rx_er    <= phy_rx_er;
          mac_rx_valid <= 1'b1;
          rx_phase     <= 1'b0;
        end else if (phy_rx_dv) begin
          if (!rx_phase) begin
            rx_lo    <= phy_rxd[3:0];
            rx_err   <= rx_err | phy_rx_er;
            rx_phase <= 1'b1;
          end else begin
            mac_rxd      <= {phy_rxd[3:0], rx_lo};
            mac_rx_dv    <= 1'b1;
            mac_rx_er    <= rx_err | phy_rx_er;
            mac_rx_valid <= 1'b1;
            rx_err       <= 1'b0;
            rx_phase     <= 1'b0;
          end
        end else begin
          rx_phase <= 1'b0;
          rx_err   <= 1'b0;
          if (rx_phase) begin
            // Odd trailing nibble: optionally surface it as an errored byte.
            if (RX_DRIBBLE_ERR != 0) begin
              mac_rxd      <= {4'h0, rx_lo};
              mac_rx_dv    <= 1'b1;
              mac_rx_er    <= 1'b1;
              mac_rx_valid <= 1'b1;
            end
          end else begin
            mac_rx_dv    <= 1'b0;
            mac_rx_er    <= 1'b0;
            mac_rx_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
